// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around a single full-adder cell.
// The operands are captured on start. The sum is then produced LSB-first, one bit
// per clock. s_o/co_o are published only once the whole word is finished.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; outputs hold the previous result
// ADD   | one full-adder step per clock over a_sh_q[0]/b_sh_q[0]/carry_q
// DONE  | result published, done_o high for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_sh_d;
  logic             last_bit_d;

  // One full-adder cell on the current LSBs, plus the sum shift register with the new bit inserted.
  always_comb begin
    sum_bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_d    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    sum_sh_d   = {sum_bit_d, sum_sh_q[WIDTH-1:1]};
    last_bit_d = (cnt_q == CW'(WIDTH - 1));
  end

  // Sequencer and datapath registers. The outputs are registered here, and s/co are written only when the word completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_sh_q   <= a_i;
            b_sh_q   <= b_i;
            carry_q  <= ci_i;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ADD;
          end
        end
        ADD: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit_d) begin
            s_q     <= sum_sh_d;
            co_q    <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;
  assign co_o   = co_q;

endmodule
